// File: rtl/bus_arbiter4.sv
// rtl/bus_arbiter4.sv - four-master round-robin bus arbiter with burst limit and turnaround
//
// Purpose:
//   Arbitrates four bus masters onto the shared DMAC bus. The registered
//   one-hot grant drives the select of the downstream 5:1 read/address mux:
//   grant == 4'b0000 selects the default path (d0), grant[3..0] select d1..d4.
//   Ownership is bounded by a burst limit while others wait. Every release
//   passes through one all-zero grant cycle before any new owner.
//
// Parameters:
//   MAX_BURST  max consecutive GRANT cycles while another master waits (>=2)
//   CNT_W      burst counter width, 2**CNT_W >= MAX_BURST
//
// Ports:
//   clk      in   1  single clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   req      in   4  level request per master, held while the bus is wanted
//   grant    out  4  registered one-hot grant, 0 = no owner
//   busy     out  1  1 while any grant bit is set
//   owner    out  2  index of granted master, meaningful only when busy=1
//   timeout  out  1  one-cycle pulse in the cycle after a forced release

module bus_arbiter4 #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       busy,
    output logic [1:0] owner,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t           state_q,   state_d;
    logic [3:0]       grant_q,   grant_d;
    logic             busy_q,    busy_d;
    logic [1:0]       owner_q,   owner_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // Round-robin pick: first set request scanning ptr, ptr+1, ... mod 4.
    logic       pick_valid;
    logic [1:0] pick_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            // Scanning backwards lets the lowest offset from ptr win last.
            logic [1:0] cand;
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Another master is waiting if any request other than the owner's is up.
    logic others_waiting;
    assign others_waiting = |(req & ~grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    grant_d = 4'b0001 << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    ptr_d   = pick_idx + 2'd1;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q]) begin
                    // Voluntary release: mandatory idle cycle before next owner.
                    state_d = ST_IDLE;
                    grant_d = 4'b0000;
                end else if (cnt_q == CNT_MAX && others_waiting) begin
                    // Burst limit reached with contention: force release.
                    state_d   = ST_IDLE;
                    grant_d   = 4'b0000;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase

        busy_d = |grant_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            owner_q   <= 2'd0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb/tb_bus_arbiter4.sv - directed self-checking bench for bus_arbiter4

module tb_bus_arbiter4;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;

    int n_tests;
    int n_fail;

    bus_arbiter4 #(.MAX_BURST(16), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant),
        .busy    (busy),
        .owner   (owner),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = 4'b0000;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Grant values expected in T3: each master owns two cycles, then one idle.
    logic [3:0] t3_exp [0:8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b1;
        req     = 4'b0000;

        // T1: reset held with all requests active.
        @(negedge clk);
        reset_n = 1'b0;
        req     = 4'b1111;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t1_rst_grant", 32'(grant), 32'h0);
            check("t1_rst_busy", 32'(busy), 32'h0);
            check("t1_rst_timeout", 32'(timeout), 32'h0);
            check("t1_rst_owner", 32'(owner), 32'h0);
            tick();
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("t1_first_grant", 32'(grant), 32'h1);
        check("t1_first_owner", 32'(owner), 32'h0);
        check("t1_first_busy", 32'(busy), 32'h1);

        // T2: single master 3, five cycles of ownership then release.
        do_reset();
        req = 4'b1000;
        tick();
        check("t2_grant", 32'(grant), 32'h8);
        check("t2_owner", 32'(owner), 32'h3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_hold", 32'(grant), 32'h8);
        end
        req = 4'b0000;
        tick();
        check("t2_release_grant", 32'(grant), 32'h0);
        check("t2_release_busy", 32'(busy), 32'h0);
        check("t2_release_timeout", 32'(timeout), 32'h0);

        // T3: all request; owner drops after two cycles, re-raises at release.
        t3_exp[0] = 4'b0001; t3_exp[1] = 4'b0000; t3_exp[2] = 4'b0010;
        t3_exp[3] = 4'b0000; t3_exp[4] = 4'b0100; t3_exp[5] = 4'b0000;
        t3_exp[6] = 4'b1000; t3_exp[7] = 4'b0000; t3_exp[8] = 4'b0001;
        do_reset();
        req = 4'b1111;
        for (int s = 0; s < 9; s += 2) begin
            tick();
            check("t3_grant", 32'(grant), 32'(t3_exp[s]));
            check("t3_owner", 32'(owner), 32'(s / 2 % 4));
            if (s < 8) begin
                tick();
                check("t3_hold", 32'(grant), 32'(t3_exp[s]));
                req = 4'b1111 & ~t3_exp[s];
                tick();
                check("t3_turnaround", 32'(grant), 32'(t3_exp[s + 1]));
                check("t3_turn_busy", 32'(busy), 32'h0);
                req = 4'b1111;
            end
        end

        // T4: master 0 holds, master 2 joins at cycle 3 -> forced release.
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) req = 4'b0101;
            tick();
            check("t4_burst_grant", 32'(grant), 32'h1);
            check("t4_burst_timeout", 32'(timeout), 32'h0);
        end
        tick();
        check("t4_forced_grant", 32'(grant), 32'h0);
        check("t4_forced_timeout", 32'(timeout), 32'h1);
        tick();
        check("t4_next_grant", 32'(grant), 32'h4);
        check("t4_next_owner", 32'(owner), 32'h2);
        check("t4_pulse_end", 32'(timeout), 32'h0);

        // T5: lone master 1 for 40 cycles, counter saturates, no timeout.
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 40; c++) begin
            tick();
            check("t5_grant", 32'(grant), 32'h2);
            check("t5_timeout", 32'(timeout), 32'h0);
        end

        // T6: async reset in the middle of a grant.
        do_reset();
        req = 4'b0100;
        tick();
        check("t6_pre_grant", 32'(grant), 32'h4);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'h0);
        check("t6_async_busy", 32'(busy), 32'h0);
        req = 4'b0110;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("t6_after_grant", 32'(grant), 32'h2);
        check("t6_after_owner", 32'(owner), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
